flash_multi: RTL and testbench
==============================

FLASH_MULTI -- requirements
Module: flash_multi

Interface
REQ-001 SHALL provide parameter CH, default 4, number of independent switch/LED channels (1..32).
REQ-002 SHALL provide parameter ON_CYC, default 4, ld high time per pulse in clk cycles (>=1).
REQ-003 SHALL provide parameter OFF_CYC, default 4, ld low time per pulse in clk cycles (>=1).
REQ-004 SHALL provide parameter PULSES, default 3, pulses per one-shot burst (>=1).
REQ-005 SHALL provide port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL provide port rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL provide port sw, input, CH, per-channel switch; bit i drives channel i.
REQ-008 SHALL provide port mode, input, CH, per-channel mode (0 = one-shot burst, 1 = continuous while held).
REQ-009 SHALL provide port ld, output, CH, per-channel LED drive, registered.
REQ-010 SHALL provide port busy, output, CH, high while channel is in ON or OFF state, registered.
REQ-011 SHALL provide port done, output, CH, one-cycle pulse on return to IDLE, registered.

Function
REQ-012 Each channel SHALL be an independent copy of the FSM and counters below; no cross-channel interaction.
REQ-013 Each channel SHALL register sw into sw_q every cycle; a trigger is sw=1 and sw_q=0 at a clock edge.
REQ-014 FSM states SHALL be IDLE, ON, OFF; ld=1 only in ON; busy=1 in ON and OFF.
REQ-015 IDLE -> ON SHALL occur at the edge where a trigger is sampled; ld=1 from that edge (zero extra latency).
REQ-016 mode SHALL be latched at the trigger edge; changes to mode during a burst SHALL be ignored.
REQ-017 ON SHALL last exactly ON_CYC cycles, then -> OFF; OFF SHALL last exactly OFF_CYC cycles.
REQ-018 One-shot: pulse counter SHALL count completed OFF phases; after the PULSES-th OFF -> IDLE, otherwise -> ON.
REQ-019 Continuous: at end of each OFF phase, -> ON if sw=1, -> IDLE if sw=0; a sw fall mid-pulse SHALL NOT truncate the current ON/OFF pair.
REQ-020 Triggers SHALL be recognised only in IDLE; edges during ON/OFF, including the final OFF cycle, SHALL be ignored.
REQ-021 done SHALL be 1 for exactly the one cycle following OFF -> IDLE transition, with busy=0 in that cycle.
REQ-022 Counter widths SHALL be clog2-sized to hold ON_CYC, OFF_CYC, PULSES without wrap; no other wrap behaviour permitted.
REQ-023 One-shot burst length SHALL be exactly PULSES*(ON_CYC+OFF_CYC) cycles of busy=1.

Reset
REQ-024 While rst=1 at an edge: all FSMs -> IDLE, counters -> 0, ld=0, busy=0, done=0 for every channel.
REQ-025 During reset sw_q SHALL load sw, so a switch held high through reset release SHALL NOT trigger.
REQ-026 Reset asserted mid-burst SHALL abort immediately (next edge) with no done pulse.
REQ-027 rst SHALL take priority over any trigger sampled at the same edge.

Verification (defaults CH=4, ON_CYC=4, OFF_CYC=4, PULSES=3; E0 = trigger edge)
REQ-028 One-shot: sw[0] 0->1 sampled at E0, mode[0]=0 -> ld[0] high after E0, E8, E16, low after E4, E12, E20; busy[0] high E0..E23; done[0]=1 after E24 for one cycle only.
REQ-029 Continuous: mode[1]=1, sw[1] high at E0, dropped before E10 -> ld[1] high E0-E3 and E8-E11, IDLE after E16, done[1] pulse after E16.
REQ-030 Retrigger ignored: sw[2] toggled 0->1 at E5 and E23 during burst -> waveform identical to REQ-028; toggle at E25 starts new burst at E25.
REQ-031 Reset mid-burst: rst=1 at E10 with sw[0] held high -> after E10 ld=busy=done=0; after release no trigger until sw[0] goes low then high.
REQ-032 Independence: channels 0 and 3 triggered at E0 and E3 -> each follows REQ-028 offset by its own E0, no interference; mode toggled mid-burst has no effect.

Source files
------------

// File: rtl/flash_multi_if.sv
// flash_multi_if: switch/mode inputs and LED/busy/done outputs for a bank of flash channels
interface flash_multi_if #(parameter int CH = 4);
    logic [CH-1:0] sw;
    logic [CH-1:0] mode;
    logic [CH-1:0] ld;
    logic [CH-1:0] busy;
    logic [CH-1:0] done;
    modport master (output sw, mode, input ld, busy, done);
    modport slave (input sw, mode, output ld, busy, done);
endinterface

// File: rtl/flash_multi.sv
// flash_multi: independent per-channel LED flashers, one-shot burst or continuous while held
module flash_multi #(
    parameter int CH      = 4,
    parameter int ON_CYC  = 4,
    parameter int OFF_CYC = 4,
    parameter int PULSES  = 3
) (
    input logic         clk,
    input logic         rst,
    flash_multi_if.slave bus
);
    localparam int MX = (ON_CYC > OFF_CYC ? ON_CYC : OFF_CYC) > PULSES ?
                        (ON_CYC > OFF_CYC ? ON_CYC : OFF_CYC) : PULSES;
    localparam int CW = $clog2(MX + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, OFF = 2'd2} state_t;
    state_t        st_q [CH];
    state_t        st_d [CH];
    logic [CW-1:0] cnt_q [CH];
    logic [CW-1:0] cnt_d [CH];
    logic [CW-1:0] pc_q [CH];
    logic [CW-1:0] pc_d [CH];
    logic [CH-1:0] sw_q, mode_q, mode_d, ld_q, busy_q, done_q;
    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        pc_d   = pc_q;
        mode_d = mode_q;
        for (int i = 0; i < CH; i++) begin
            case (st_q[i])
                IDLE: if (bus.sw[i] && !sw_q[i]) begin
                    st_d[i]   = ON;
                    cnt_d[i]  = '0;
                    pc_d[i]   = '0;
                    mode_d[i] = bus.mode[i];
                end
                ON: begin
                    st_d[i]  = cnt_q[i] == CW'(ON_CYC - 1) ? OFF : ON;
                    cnt_d[i] = cnt_q[i] == CW'(ON_CYC - 1) ? '0 : cnt_q[i] + CW'(1);
                end
                OFF: if (cnt_q[i] == CW'(OFF_CYC - 1)) begin
                    cnt_d[i] = '0;
                    // continuous mode decides on the live switch; one-shot on completed pulses
                    st_d[i]  = (mode_q[i] ? !bus.sw[i] : pc_q[i] == CW'(PULSES - 1)) ? IDLE : ON;
                    pc_d[i]  = mode_q[i] ? pc_q[i] : pc_q[i] + CW'(1);
                end else cnt_d[i] = cnt_q[i] + CW'(1);
                default: st_d[i] = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        sw_q <= bus.sw;
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                st_q[i]  <= IDLE;
                cnt_q[i] <= '0;
                pc_q[i]  <= '0;
            end
            mode_q <= '0;
            ld_q   <= '0;
            busy_q <= '0;
            done_q <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            pc_q   <= pc_d;
            mode_q <= mode_d;
            for (int i = 0; i < CH; i++) begin
                ld_q[i]   <= st_d[i] == ON;
                busy_q[i] <= st_d[i] != IDLE;
                done_q[i] <= st_q[i] == OFF && st_d[i] == IDLE;
            end
        end
    end
    assign bus.ld   = ld_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_flash_multi.sv
// tb_flash_multi: random switch/mode/reset stimulus checked against a time-since-trigger model
module tb_flash_multi;
    localparam int CH = 4;
    localparam int ON_CYC = 4;
    localparam int OFF_CYC = 4;
    localparam int PULSES = 3;
    localparam int P = ON_CYC + OFF_CYC;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    flash_multi_if #(.CH(CH)) bus ();
    flash_multi #(.CH(CH), .ON_CYC(ON_CYC), .OFF_CYC(OFF_CYC), .PULSES(PULSES)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    initial begin
        bit act [CH];
        bit md [CH];
        bit psw [CH];
        int st [CH];
        logic [CH-1:0] e_ld, e_busy, e_done;
        int e;
        bit fin;
        for (int i = 0; i < CH; i++) begin
            act[i] = 0;
            md[i] = 0;
            psw[i] = 0;
            st[i] = 0;
        end
        bus.sw = '1;
        bus.mode = '0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            rst = n < 3 || $urandom_range(0, 299) == 0;
            if (n >= 3)
                for (int i = 0; i < CH; i++)
                    if ($urandom_range(0, 7) == 0) bus.sw[i] = ~bus.sw[i];
            bus.mode = CH'($urandom);
            @(posedge clk);
            for (int i = 0; i < CH; i++) begin
                e_ld[i] = 0;
                e_busy[i] = 0;
                e_done[i] = 0;
                if (rst) act[i] = 0;
                else begin
                    fin = 0;
                    if (act[i]) begin
                        e = n - st[i];
                        if (e % P == 0 && (md[i] ? !bus.sw[i] : e / P == PULSES)) begin
                            act[i] = 0;
                            fin = 1;
                            e_done[i] = 1;
                        end
                    end else if (bus.sw[i] && !psw[i]) begin
                        act[i] = 1;
                        st[i] = n;
                        md[i] = bus.mode[i];
                    end
                    e_busy[i] = act[i];
                    e_ld[i] = act[i] && ((n - st[i]) % P) < ON_CYC;
                end
                psw[i] = bus.sw[i];
            end
            #1;
            chk($sformatf("ld@%0d", n), 32'(bus.ld), 32'(e_ld));
            chk($sformatf("busy@%0d", n), 32'(bus.busy), 32'(e_busy));
            chk($sformatf("done@%0d", n), 32'(bus.done), 32'(e_done));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
